// File: rtl/dmem_responder.sv
//------------------------------------------------------------------------------
// Module      : dmem_responder
// Description : Data-memory responder for MEM-stage loads/stores with byte-lane
//               steering, load extension, error checks and fixed wait states.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module dmem_responder #(
    parameter int DEPTH       = 4096,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    input  logic [3:0]            req_op_i,
    input  logic [31:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  req_ready_o,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  stall_o
);

    localparam int c_IDX_W = $clog2(DEPTH);

    // MEM_OP_t encoding: bit 3 marks stores, bit 2 marks unsigned loads
    localparam logic [3:0] c_OP_LB  = 4'b0000;
    localparam logic [3:0] c_OP_LH  = 4'b0001;
    localparam logic [3:0] c_OP_LW  = 4'b0010;
    localparam logic [3:0] c_OP_LBU = 4'b0100;
    localparam logic [3:0] c_OP_LHU = 4'b0101;
    localparam logic [3:0] c_OP_SB  = 4'b1000;
    localparam logic [3:0] c_OP_SH  = 4'b1001;
    localparam logic [3:0] c_OP_SW  = 4'b1010;
    localparam logic [3:0] c_OP_NOP = 4'b1111;

    localparam logic [1:0] c_SZ_B = 2'd0;
    localparam logic [1:0] c_SZ_H = 2'd1;
    localparam logic [1:0] c_SZ_W = 2'd2;

    localparam logic       c_NO_WAIT = (WAIT_STATES == 0);
    localparam logic [2:0] c_WS      = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [2:0]      r_cnt;
    logic [3:0]      r_op;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_mem [DEPTH];

    logic               w_accept;
    logic               w_commit;
    logic [3:0]         w_op;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;
    logic               w_legal;
    logic               w_store;
    logic               w_signed;
    logic [1:0]         w_size;
    logic               w_misal;
    logic               w_oor;
    logic               w_err;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_rword;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;
    logic [3:0]         w_be;
    logic [31:0]        w_wword;

    assign w_accept = (r_state == S_IDLE) && req_valid_i && (req_op_i != c_OP_NOP);

    // With zero wait states the access commits on the accept edge itself,
    // so the live request fields feed the datapath instead of the captures.
    assign w_commit = (w_accept && c_NO_WAIT) || ((r_state == S_WAIT) && (r_cnt == 3'd1));
    assign w_op     = (r_state == S_IDLE) ? req_op_i    : r_op;
    assign w_addr   = (r_state == S_IDLE) ? req_addr_i  : r_addr;
    assign w_wdata  = (r_state == S_IDLE) ? req_wdata_i : r_wdata;

    always_comb begin
        w_legal  = 1'b1;
        w_store  = 1'b0;
        w_signed = 1'b0;
        w_size   = c_SZ_B;
        case (w_op)
            c_OP_LB:  w_signed = 1'b1;
            c_OP_LH:  begin w_signed = 1'b1; w_size = c_SZ_H; end
            c_OP_LW:  w_size = c_SZ_W;
            c_OP_LBU: w_size = c_SZ_B;
            c_OP_LHU: w_size = c_SZ_H;
            c_OP_SB:  w_store = 1'b1;
            c_OP_SH:  begin w_store = 1'b1; w_size = c_SZ_H; end
            c_OP_SW:  begin w_store = 1'b1; w_size = c_SZ_W; end
            default:  w_legal = 1'b0;
        endcase
    end

    assign w_misal = ((w_size == c_SZ_H) && w_addr[0]) ||
                     ((w_size == c_SZ_W) && (w_addr[1:0] != 2'b00));
    assign w_oor   = ({2'b00, w_addr[31:2]} >= 32'(DEPTH));
    assign w_err   = !w_legal || w_misal || w_oor;

    assign w_idx   = w_addr[c_IDX_W+1:2];
    assign w_rword = r_mem[w_idx];
    assign w_byte  = w_rword[{w_addr[1:0], 3'b000} +: 8];
    assign w_half  = w_rword[{w_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load = w_rword;
        case (w_size)
            c_SZ_B:  w_load = {{24{w_signed & w_byte[7]}}, w_byte};
            c_SZ_H:  w_load = {{16{w_signed & w_half[15]}}, w_half};
            default: w_load = w_rword;
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wword = w_wdata;
        case (w_size)
            c_SZ_B: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_wword = {4{w_wdata[7:0]}};
            end
            c_SZ_H: begin
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wword = {2{w_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wword = w_wdata;
            end
        endcase
    end

    // Storage array carries no reset; only committed, error-free stores write.
    always_ff @(posedge clk) begin
        if (w_commit && w_store && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_op        <= 4'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= req_op_i;
                        r_addr  <= req_addr_i;
                        r_wdata <= req_wdata_i;
                        r_cnt   <= c_WS;
                        r_state <= c_NO_WAIT ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            rsp_valid_o <= w_commit;
            if (w_commit) begin
                rsp_err_o   <= w_err;
                rsp_rdata_o <= (w_err || w_store) ? '0 : w_load;
            end
        end
    end

    assign req_ready_o = (r_state == S_IDLE);
    assign stall_o     = w_accept || (r_state == S_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_dmem_responder
// Description : Randomized self-checking bench for dmem_responder against a
//               word-array reference model (two instances: 2 and 0 wait states).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_responder;

    localparam int DEPTH = 4096;
    localparam int WS_A  = 2;
    localparam int WS_B  = 0;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;
    localparam logic [3:0] OP_NOP = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic [3:0]  a_op, b_op;
    logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
    logic        a_ready, b_ready, a_rsp_valid, b_rsp_valid;
    logic [31:0] a_rdata, b_rdata;
    logic        a_err, b_err, a_stall, b_stall;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl_a [int];
    logic [31:0] mdl_b [int];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .DATA_WIDTH(32), .WAIT_STATES(WS_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(a_valid), .req_op_i(a_op), .req_addr_i(a_addr), .req_wdata_i(a_wdata),
        .req_ready_o(a_ready), .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rdata),
        .rsp_err_o(a_err), .stall_o(a_stall)
    );

    dmem_responder #(.DEPTH(DEPTH), .DATA_WIDTH(32), .WAIT_STATES(WS_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(b_valid), .req_op_i(b_op), .req_addr_i(b_addr), .req_wdata_i(b_wdata),
        .req_ready_o(b_ready), .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rdata),
        .rsp_err_o(b_err), .stall_o(b_stall)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: memory as an array of words, accesses as shifts and masks.
    function automatic void model(input bit sel, input logic [3:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] rdata,
                                  output logic err);
        int          size;
        bit          store, sext, legal;
        int          wi, sh;
        logic [63:0] lmask, old, v;
        size = 1; store = 0; sext = 0; legal = 1;
        case (op)
            OP_LB:   begin size = 1; sext = 1; end
            OP_LH:   begin size = 2; sext = 1; end
            OP_LW:   size = 4;
            OP_LBU:  size = 1;
            OP_LHU:  size = 2;
            OP_SB:   begin size = 1; store = 1; end
            OP_SH:   begin size = 2; store = 1; end
            OP_SW:   begin size = 4; store = 1; end
            default: legal = 0;
        endcase
        err   = !legal || ((addr % size) != 0) || ((addr >> 2) >= DEPTH);
        rdata = 32'h0;
        if (!err) begin
            wi    = int'(addr >> 2);
            sh    = 8 * int'(addr[1:0]);
            old   = 64'h0;
            if (sel && mdl_b.exists(wi))  old = {32'h0, mdl_b[wi]};
            if (!sel && mdl_a.exists(wi)) old = {32'h0, mdl_a[wi]};
            lmask = (64'd1 << (8 * size)) - 64'd1;
            if (store) begin
                v = (old & ~(lmask << sh)) | (({32'h0, wdata} & lmask) << sh);
                if (sel) mdl_b[wi] = v[31:0];
                else     mdl_a[wi] = v[31:0];
            end else begin
                v = (old >> sh) & lmask;
                if (sext && v[8*size-1]) v = v | ~lmask;
                rdata = v[31:0];
            end
        end
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [3:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin b_valid = v; b_op = op; b_addr = addr; b_wdata = wdata; end
        else     begin a_valid = v; a_op = op; a_addr = addr; a_wdata = wdata; end
    endtask

    task automatic do_req(input bit sel, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        int          ws;
        ws = sel ? WS_B : WS_A;
        model(sel, op, addr, wdata, exp_rd, exp_err);
        @(posedge clk); #1;
        drive(sel, 1'b1, op, addr, wdata);
        @(negedge clk);
        check_val({tag, "_stall_acc"}, 32'(sel ? b_stall : a_stall), 32'd1);
        check_val({tag, "_ready_acc"}, 32'(sel ? b_ready : a_ready), 32'd1);
        @(posedge clk); #1;
        drive(sel, 1'b0, OP_NOP, 32'h0, 32'h0);
        lat = 1;
        while (lat <= 20) begin
            @(negedge clk);
            if (sel ? b_rsp_valid : a_rsp_valid) break;
            check_val({tag, "_stall_wait"}, 32'(sel ? b_stall : a_stall), 32'd1);
            lat++;
        end
        check_val({tag, "_latency"}, 32'(lat), 32'(ws + 1));
        check_val({tag, "_rdata"}, sel ? b_rdata : a_rdata, exp_rd);
        check_val({tag, "_err"}, 32'(sel ? b_err : a_err), 32'(exp_err));
        check_val({tag, "_stall_rsp"}, 32'(sel ? b_stall : a_stall), 32'd0);
        @(negedge clk);
        check_val({tag, "_pulse"}, 32'(sel ? b_rsp_valid : a_rsp_valid), 32'd0);
        check_val({tag, "_ready_after"}, 32'(sel ? b_ready : a_ready), 32'd1);
        check_val({tag, "_rdata_hold"}, sel ? b_rdata : a_rdata, exp_rd);
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] ops [14];
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
                OP_LW, OP_SW, 4'b0011, 4'b0110, 4'b1011, 4'b1100};
        return ops[$urandom_range(13)];
    endfunction

    function automatic logic [31:0] rand_addr(input bit sel);
        int pick;
        pick = int'($urandom_range(9));
        if (sel)       return 32'h40 + 32'($urandom_range(63));
        if (pick < 6)  return 32'($urandom_range(63));
        if (pick < 9)  return 32'((DEPTH - 4) * 4) + 32'($urandom_range(15));
        return 32'(DEPTH * 4) + 32'($urandom_range(1 << 20));
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, OP_NOP, 32'h0, 32'h0);
        drive(1'b1, 1'b0, OP_NOP, 32'h0, 32'h0);
        #12;
        check_val("reset_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check_val("reset_rdata", a_rdata, 32'h0);
        check_val("reset_err", 32'(a_err), 32'd0);
        check_val("reset_ready", 32'(a_ready), 32'd1);
        check_val("reset_stall", 32'(a_stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_req(0, OP_SW,  32'h10, 32'hDEADBEEF, "t1_sw");
        do_req(0, OP_LW,  32'h10, 32'h0, "t1_lw");
        do_req(0, OP_SB,  32'h13, 32'h00000080, "t2_sb");
        do_req(0, OP_LB,  32'h13, 32'h0, "t2_lb");
        do_req(0, OP_LBU, 32'h13, 32'h0, "t2_lbu");
        do_req(0, OP_LW,  32'h10, 32'h0, "t2_lw");
        do_req(0, OP_SH,  32'h12, 32'h00001234, "t3_sh");
        do_req(0, OP_LW,  32'h10, 32'h0, "t3_lw");
        do_req(0, OP_LH,  32'h11, 32'h0, "t3_lh_mis");
        do_req(0, OP_SW,  32'h12, 32'h55555555, "t3_sw_mis");
        do_req(0, OP_LW,  32'h10, 32'h0, "t3_lw_unch");
        do_req(0, 4'b0011, 32'h0, 32'h0, "t3_illegal");
        do_req(0, OP_SW,  32'h0, 32'h5A5A0001, "t4_sw0");
        do_req(0, OP_SW,  32'h4000, 32'hCAFEF00D, "t4_sw_oor");
        do_req(0, OP_LW,  32'h0, 32'h0, "t4_lw0");

        for (int i = 0; i < 16; i++) do_req(0, OP_SW, 32'(i * 4), $urandom, "init_lo");
        for (int i = DEPTH - 4; i < DEPTH; i++) do_req(0, OP_SW, 32'(i * 4), $urandom, "init_hi");
        for (int i = 0; i < 150; i++) do_req(0, rand_op(), rand_addr(0), $urandom, "rnd_a");

        // Reset while a store sits in WAIT: the store must be dropped.
        do_req(0, OP_SW, 32'h20, 32'h11111111, "t5_sw1");
        do_req(0, OP_LW, 32'h20, 32'h0, "t5_lw1");
        @(posedge clk); #1;
        drive(0, 1'b1, OP_SW, 32'h20, 32'h22222222);
        @(posedge clk); #1;
        drive(0, 1'b0, OP_NOP, 32'h0, 32'h0);
        @(negedge clk);
        check_val("t5_stall_wait", 32'(a_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_valid", 32'(a_rsp_valid), 32'd0);
        check_val("t5_rst_rdata", a_rdata, 32'h0);
        check_val("t5_rst_err", 32'(a_err), 32'd0);
        check_val("t5_rst_ready", 32'(a_ready), 32'd1);
        check_val("t5_rst_stall", 32'(a_stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_req(0, OP_LW, 32'h20, 32'h0, "t5_lw2");

        do_req(1, OP_SW, 32'h40, 32'h0BADF00D, "t6_sw");
        do_req(1, OP_LW, 32'h40, 32'h0, "t6_lw");
        @(posedge clk); #1;
        drive(1, 1'b1, OP_NOP, 32'h40, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("t6_nop_stall", 32'(b_stall), 32'd0);
            check_val("t6_nop_valid", 32'(b_rsp_valid), 32'd0);
            check_val("t6_nop_ready", 32'(b_ready), 32'd1);
        end
        @(posedge clk); #1;
        drive(1, 1'b0, OP_NOP, 32'h0, 32'h0);
        for (int i = 16; i < 32; i++) do_req(1, OP_SW, 32'(i * 4), $urandom, "init_b");
        for (int i = 0; i < 60; i++) do_req(1, rand_op(), rand_addr(1), $urandom, "rnd_b");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving the core's MEM-stage load/store requests (the memory-side end of the core's data-memory control bus). It accepts one request at a time, carrying a MEM_OP_t opcode, address and store data. It performs byte-lane steering, load sign/zero extension, alignment and range checks, and adds a programmable number of wait states. It drives a stall to the pipeline until the single-cycle response pulse is issued.

Parameters:
DEPTH, 4096, number of 32-bit words; word index is addr[$clog2(DEPTH)+1:2]
DATA_WIDTH, 32, data width; fixed at 32
WAIT_STATES, 1, extra cycles between accept and response; legal range 0..7

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  reset; asynchronous, active-low
req_valid_i  input  1  MEM stage presents a request; held stable while stall_o=1
req_op_i  input  4  MEM_OP_t: LB/LH/LW/LBU/LHU/SB/SH/SW/MEM_NOP
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_ready_o  output  1  responder can accept a request this cycle
rsp_valid_o  output  1  one-cycle response pulse
rsp_rdata_o  output  32  extended load data; 0 for stores and errors
rsp_err_o  output  1  misaligned, illegal-op or out-of-range access; valid with rsp_valid_o
stall_o  output  1  freeze pipeline at and before MEM

Behaviour:
- Clock/reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; wait counter=0; captured op/addr/wdata=0. Memory array is not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready_o=1.
  - Accept when req_valid_i=1 and req_op_i!=MEM_NOP. On the accept edge: capture op, addr and wdata; load counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
  - MEM_NOP or req_valid_i=0: no accept, no stall, remain in IDLE.
- WAIT: req_ready_o=0; counter decrements each cycle; go to RESP on the edge where counter==1. Inputs are ignored.
- RESP: req_ready_o=0; rsp_valid_o=1 for exactly one cycle; next state IDLE. There is no response backpressure.
- Commit point: memory read/write executes on the edge entering RESP. Registered outputs are updated on the same edge.
- Latency: request accepted at cycle T gives rsp_valid_o at cycle T+1+WAIT_STATES. Throughput is one request per WAIT_STATES+2 cycles.
- stall_o (combinational) = (IDLE & req_valid_i & op!=MEM_NOP) | WAIT. stall_o=0 in RESP, so the pipeline advances on the response cycle.
- Error checks (any check failing sets rsp_err_o=1, rsp_rdata_o=0, and suppresses the write):
  - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
  - Illegal op: any encoding outside the nine defined values.
  - Out of range: addr[31:2] >= DEPTH. No wrap-around.
- Store byte steering:
  - SB: byte lane addr[1:0] gets wdata[7:0].
  - SH: lanes {addr[1],1'b1} and {addr[1],1'b0} get wdata[15:0].
  - SW: all four lanes. Lanes not written keep their old value.
- Load extraction:
  - LB/LBU: byte at addr[1:0], sign-/zero-extended to 32 bits.
  - LH/LHU: half at addr[1], sign-/zero-extended to 32 bits.
  - LW: full word.
- Reset mid-operation: request in WAIT is discarded, store not written. A store that already reached RESP is committed.
- rsp_rdata_o and rsp_err_o hold their values until the next response or reset. They are qualified only by rsp_valid_o.

Test Plan:
1. WAIT_STATES=2; SW 0xDEADBEEF @0x10 accepted at T -> stall_o=1 at T..T+2, rsp_valid_o at T+3, err=0; then LW @0x10 -> rdata 0xDEADBEEF.
2. After (1), SB wdata=0x80 @0x13 -> LB @0x13 = 0xFFFFFF80; LBU @0x13 = 0x00000080; LW @0x10 = 0x80ADBEEF.
3. SH wdata=0x1234 @0x12 -> LW @0x10 = 0x1234BEEF. LH @0x11 -> err=1, rdata=0. SW @0x12 -> err=1 and memory unchanged. req_op_i=4'b0011 -> err=1.
4. DEPTH=4096: SW 0xCAFEF00D @0x4000 -> err=1; LW @0x0 still returns its prior value (no wrap).
5. SW 0x11111111 @0x20, then SW 0x22222222 @0x20 with rst_n pulsed low during WAIT -> all outputs 0 asynchronously, state=IDLE; LW @0x20 = 0x11111111.
6. WAIT_STATES=0: LW at T -> rsp_valid_o at T+1, req_ready_o=1 at T+2. req_valid_i=1 with MEM_NOP -> stall_o=0, no rsp_valid_o for 5 cycles.
